sram_access_sequencer: RTL and testbench

//  Front-end controller for the 32-bit SRAM array. It turns single-cycle CPU load/store requests

---
 rtl/sram_access_sequencer_pkg.sv | 25 ++
 rtl/sram_access_sequencer_phase_timer.sv | 42 ++++
 rtl/sram_access_sequencer.sv | 134 +++++++++++++
 tb/tb_sram_access_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_access_sequencer_pkg.sv
// Shared definitions for the SRAM access sequencer: sequencer states, default widths
// and the active level of the SRAM output enable.
package sram_access_sequencer_pkg;

    localparam int DEF_ADDR_W        = 11;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_STROBE_CYCLES = 1;

    // OE is active low: 0 means the SRAM drives DataBus
    localparam logic OE_ACTIVE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_S1    = 3'd2,
        ST_S2    = 3'd3,
        ST_S3    = 3'd4,
        ST_RESP  = 3'd5
    } seq_state_e;

    function automatic logic is_strobe_state(input seq_state_e s);
        return (s == ST_S1) || (s == ST_S2) || (s == ST_S3);
    endfunction

endpackage

// File: rtl/sram_access_sequencer_phase_timer.sv
// Phase counter for one strobe phase: 2*STROBE_CYCLES cycles, restarted on each phase entry.
// strobe_hi is the strobe level for the coming cycle so the strobe pins can be registered.
module sram_access_sequencer_phase_timer
    import sram_access_sequencer_pkg::*;
#(
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic strobe_hi,
    output logic phase_done
);

    localparam int PERIOD = 2 * STROBE_CYCLES;
    localparam int CW     = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST    = CW'(PERIOD - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(STROBE_CYCLES - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign phase_done = (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (restart || phase_done) begin
            cnt_next = '0;
        end
    end

    assign strobe_hi = (cnt_next <= HI_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/sram_access_sequencer.sv
// Turns single-cycle CPU load/store requests into the SRAM three-strobe protocol
// and returns the result over a valid/ready response port. Every pin is a register.
module sram_access_sequencer
    import sram_access_sequencer_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspRData,
    output logic [ADDR_W-1:0] AdxBus,
    output logic              RNW,
    output logic              OE,
    output logic              Strobe1,
    output logic              Strobe2,
    output logic              Strobe3,
    inout  wire  [DATA_W-1:0] DataBus
);

    localparam seq_state_e STROBE_ST [3] = '{ST_S1, ST_S2, ST_S3};

    seq_state_e        state_reg, state_next;
    logic              write_reg, write_next;
    logic [ADDR_W-1:0] adx_reg, adx_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              ready_reg, ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rnw_reg, rnw_next;
    logic              oe_reg, oe_next;
    logic              drive_reg, drive_next;
    logic [2:0]        strobe_reg, strobe_next;
    logic              restart, strobe_hi, phase_done;

    sram_access_sequencer_phase_timer #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_timer (
        .clk       (Clock),
        .rst_n     (nReset),
        .restart   (restart),
        .strobe_hi (strobe_hi),
        .phase_done(phase_done)
    );

    always_comb begin
        state_next = state_reg;
        write_next = write_reg;
        adx_next   = adx_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ReqValid && ready_reg) begin
                    state_next = ST_SETUP;
                    write_next = ReqWrite;
                    adx_next   = ReqAddr;
                    wdata_next = ReqWData;
                end
            end
            ST_SETUP: state_next = ST_S1;
            ST_S1:    if (phase_done) state_next = ST_S2;
            ST_S2:    if (phase_done) state_next = ST_S3;
            ST_S3: begin
                // Sampled on the same edge that returns OE high, while the SRAM still drives
                if (phase_done) begin
                    state_next = ST_RESP;
                    rdata_next = write_reg ? '0 : DataBus;
                end
            end
            ST_RESP:  if (RspReady) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        restart        = (state_next != state_reg) && is_strobe_state(state_next);
        rnw_next       = !(write_next && (state_next inside {ST_SETUP, ST_S1, ST_S2, ST_S3}));
        drive_next     = write_next && (state_next inside {ST_SETUP, ST_S1, ST_S2});
        oe_next        = (!write_next && state_next == ST_S3) ? OE_ACTIVE : !OE_ACTIVE;
        ready_next     = (state_next == ST_IDLE);
        rsp_valid_next = (state_next == ST_RESP);
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
        assign strobe_next[gi] = strobe_hi && (state_next == STROBE_ST[gi]);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg     <= ST_IDLE;
            write_reg     <= 1'b0;
            adx_reg       <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rnw_reg       <= 1'b1;
            oe_reg        <= !OE_ACTIVE;
            drive_reg     <= 1'b0;
            strobe_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            write_reg     <= write_next;
            adx_reg       <= adx_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rnw_reg       <= rnw_next;
            oe_reg        <= oe_next;
            drive_reg     <= drive_next;
            strobe_reg    <= strobe_next;
        end
    end

    assign ReqReady = ready_reg;
    assign RspValid = rsp_valid_reg;
    assign RspRData = rdata_reg;
    assign AdxBus   = adx_reg;
    assign RNW      = rnw_reg;
    assign OE       = oe_reg;
    assign Strobe1  = strobe_reg[0];
    assign Strobe2  = strobe_reg[1];
    assign Strobe3  = strobe_reg[2];
    assign DataBus  = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench: two sequencers (STROBE_CYCLES=1 and 3), each with a behavioural SRAM on its pins.
module tb_sram_access_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_reset;
    logic mem_init;
    int   vectors = 0;
    int   miscompares = 0;

    // instance A: STROBE_CYCLES = 1
    logic        req_valid_a, req_ready_a, req_write_a, rsp_valid_a, rsp_ready_a;
    logic [10:0] req_addr_a, adx_a;
    logic [31:0] req_wdata_a, rsp_rdata_a;
    logic        rnw_a, oe_a, s1_a, s2_a, s3_a;
    wire  [31:0] data_bus_a;

    // instance B: STROBE_CYCLES = 3
    logic        req_valid_b, req_ready_b, req_write_b, rsp_valid_b, rsp_ready_b;
    logic [10:0] req_addr_b, adx_b;
    logic [31:0] req_wdata_b, rsp_rdata_b;
    logic        rnw_b, oe_b, s1_b, s2_b, s3_b;
    wire  [31:0] data_bus_b;

    sram_access_sequencer #(.ADDR_W(11), .DATA_W(32), .STROBE_CYCLES(1)) u_dut_a (
        .Clock(clk), .nReset(n_reset),
        .ReqValid(req_valid_a), .ReqReady(req_ready_a), .ReqWrite(req_write_a),
        .ReqAddr(req_addr_a), .ReqWData(req_wdata_a),
        .RspValid(rsp_valid_a), .RspReady(rsp_ready_a), .RspRData(rsp_rdata_a),
        .AdxBus(adx_a), .RNW(rnw_a), .OE(oe_a),
        .Strobe1(s1_a), .Strobe2(s2_a), .Strobe3(s3_a), .DataBus(data_bus_a)
    );

    sram_access_sequencer #(.ADDR_W(11), .DATA_W(32), .STROBE_CYCLES(3)) u_dut_b (
        .Clock(clk), .nReset(n_reset),
        .ReqValid(req_valid_b), .ReqReady(req_ready_b), .ReqWrite(req_write_b),
        .ReqAddr(req_addr_b), .ReqWData(req_wdata_b),
        .RspValid(rsp_valid_b), .RspReady(rsp_ready_b), .RspRData(rsp_rdata_b),
        .AdxBus(adx_b), .RNW(rnw_b), .OE(oe_b),
        .Strobe1(s1_b), .Strobe2(s2_b), .Strobe3(s3_b), .DataBus(data_bus_b)
    );

    // SRAM models: unwritten words read as {16'hC0DE, 6'b0, addr}; only addr[9:0] is decoded
    function automatic logic [31:0] preload(input logic [9:0] a);
        return {16'hC0DE, 6'b0, a};
    endfunction

    logic [9:0]  lat_addr_a, lat_addr_b;
    logic [31:0] mdr_a, mdr_b;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [1023:0] written_a, written_b;
    int s3_rise_a = 0;

    always @(posedge s1_a) lat_addr_a <= adx_a[9:0];
    always @(posedge s2_a) mdr_a <= rnw_a ? (written_a[lat_addr_a] ? mem_a[lat_addr_a] : preload(lat_addr_a)) : data_bus_a;
    always @(posedge s3_a or posedge mem_init) begin
        if (mem_init) written_a <= '0;
        else if (!rnw_a) begin
            mem_a[lat_addr_a]     <= mdr_a;
            written_a[lat_addr_a] <= 1'b1;
        end
    end
    always @(posedge s3_a) s3_rise_a <= s3_rise_a + 1;
    assign data_bus_a = (!oe_a && rnw_a) ? mdr_a : 32'hzzzz_zzzz;

    always @(posedge s1_b) lat_addr_b <= adx_b[9:0];
    always @(posedge s2_b) mdr_b <= rnw_b ? (written_b[lat_addr_b] ? mem_b[lat_addr_b] : preload(lat_addr_b)) : data_bus_b;
    always @(posedge s3_b or posedge mem_init) begin
        if (mem_init) written_b <= '0;
        else if (!rnw_b) begin
            mem_b[lat_addr_b]     <= mdr_b;
            written_b[lat_addr_b] <= 1'b1;
        end
    end
    assign data_bus_b = (!oe_b && rnw_b) ? mdr_b : 32'hzzzz_zzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bench-side knowledge of when a store is in flight, for the RNW monitor
    logic store_flag_a = 1'b0;
    logic store_flag_b = 1'b0;
    int run1_b = 0, run2_b = 0, run3_b = 0;
    int last1_b = 0, last2_b = 0, last3_b = 0;

    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (oe_a === 1'b0) chk("bus_oe_low_a", data_bus_a, mdr_a);
            if (oe_b === 1'b0) chk("bus_oe_low_b", data_bus_b, mdr_b);
            if (rnw_a === 1'b0) chk("rnw_store_only_a", {31'b0, store_flag_a}, 32'd1);
            if (rnw_b === 1'b0) chk("rnw_store_only_b", {31'b0, store_flag_b}, 32'd1);
            if (s1_b) run1_b++; else begin if (run1_b != 0) last1_b = run1_b; run1_b = 0; end
            if (s2_b) run2_b++; else begin if (run2_b != 0) last2_b = run2_b; run2_b = 0; end
            if (s3_b) run3_b++; else begin if (run3_b != 0) last3_b = run3_b; run3_b = 0; end
        end
    end

    // Issue one request to A, wait for its response, hold RspReady low for `hold` cycles, then take it
    task automatic run_a(input logic w, input logic [10:0] a, input logic [31:0] d, input int hold,
                         output int lat, output logic [31:0] rd);
        int n;
        @(negedge clk);
        req_write_a = w; req_addr_a = a; req_wdata_a = d; req_valid_a = 1'b1;
        if (w) store_flag_a = 1'b1;
        n = 0;
        while (req_ready_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid_a = 1'b0;
        lat = 1;
        while (rsp_valid_a !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        rd = rsp_rdata_a;
        for (int i = 0; i < hold; i++) begin
            req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 11'h3FF;
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rsp_valid_a}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata_a, rd);
            chk("hold_req_ready", {31'b0, req_ready_a}, 32'd0);
        end
        req_valid_a = 1'b0;
        rsp_ready_a = 1'b1;
        @(negedge clk);
        rsp_ready_a = 1'b0;
        store_flag_a = 1'b0;
        $display("A %s addr=0x%03h wdata=0x%08h latency=%0d rdata=0x%08h", w ? "store" : "load ", a, d, lat, rd);
    endtask

    task automatic run_b(input logic w, input logic [10:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd);
        int n;
        @(negedge clk);
        req_write_b = w; req_addr_b = a; req_wdata_b = d; req_valid_b = 1'b1;
        if (w) store_flag_b = 1'b1;
        n = 0;
        while (req_ready_b !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid_b = 1'b0;
        lat = 1;
        while (rsp_valid_b !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        rd = rsp_rdata_b;
        rsp_ready_b = 1'b1;
        @(negedge clk);
        rsp_ready_b = 1'b0;
        store_flag_b = 1'b0;
        $display("B %s addr=0x%03h wdata=0x%08h latency=%0d rdata=0x%08h", w ? "store" : "load ", a, d, lat, rd);
    endtask

    initial begin
        int          lat, n, s3_before;
        logic [31:0] rd;

        n_reset = 1'b1; mem_init = 1'b0;
        req_valid_a = 0; req_write_a = 0; req_addr_a = '0; req_wdata_a = '0; rsp_ready_a = 0;
        req_valid_b = 0; req_write_b = 0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 0;
        #1 n_reset = 1'b0; mem_init = 1'b1;
        #1 mem_init = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready_a}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_a, 32'd0);
        chk("rst_adx", {21'b0, adx_a}, 32'd0);
        chk("rst_rnw_oe", {30'b0, rnw_a, oe_a}, 32'd3);
        chk("rst_strobes", {29'b0, s1_a, s2_a, s3_a}, 32'd0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        // 1: store/load at the top of the decoded range
        run_a(1'b1, 11'h3FF, 32'hDEADBEEF, 0, lat, rd);
        chk("t1_store_latency", lat, 32'd8);
        chk("t1_store_rdata", rd, 32'd0);
        run_a(1'b0, 11'h3FF, 32'h0, 0, lat, rd);
        chk("t1_load_latency", lat, 32'd8);
        chk("t1_load_rdata", rd, 32'hDEADBEEF);

        // 2: neighbouring word untouched, stored word intact, bit 10 not decoded
        run_a(1'b1, 11'h000, 32'h12345678, 0, lat, rd);
        run_a(1'b0, 11'h001, 32'h0, 0, lat, rd);
        chk("t2_load_001", rd, 32'hC0DE0001);
        run_a(1'b0, 11'h000, 32'h0, 0, lat, rd);
        chk("t2_load_000", rd, 32'h12345678);
        run_a(1'b0, 11'h400, 32'h0, 0, lat, rd);
        chk("t2_load_400", rd, 32'h12345678);

        // 3: reset during S2 of a store
        @(negedge clk);
        req_write_a = 1'b1; req_addr_a = 11'h010; req_wdata_a = 32'hFFFFFFFF; req_valid_a = 1'b1;
        store_flag_a = 1'b1;
        n = 0;
        while (req_ready_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_in_s2", {31'b0, s2_a}, 32'd1);
        s3_before = s3_rise_a;
        #1 n_reset = 1'b0;
        #1;
        chk("t3_rst_req_ready", {31'b0, req_ready_a}, 32'd1);
        chk("t3_rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        chk("t3_rst_adx", {21'b0, adx_a}, 32'd0);
        chk("t3_rst_rnw_oe", {30'b0, rnw_a, oe_a}, 32'd3);
        chk("t3_rst_strobes", {29'b0, s1_a, s2_a, s3_a}, 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        store_flag_a = 1'b0;
        chk("t3_no_strobe3", s3_rise_a, s3_before);
        run_a(1'b0, 11'h010, 32'h0, 0, lat, rd);
        chk("t3_load_010", rd, 32'hC0DE0010);

        // 4: response back-pressure, then the next request proceeds normally
        run_a(1'b0, 11'h002, 32'h0, 5, lat, rd);
        chk("t4_latency", lat, 32'd8);
        chk("t4_rdata", rd, 32'hC0DE0002);
        run_a(1'b0, 11'h3FF, 32'h0, 0, lat, rd);
        chk("t4_next_latency", lat, 32'd8);
        chk("t4_next_rdata", rd, 32'hDEADBEEF);

        // 5: three-cycle strobes
        run_b(1'b1, 11'h155, 32'hA5A5A5A5, lat, rd);
        chk("t5_store_latency", lat, 32'd20);
        chk("t5_strobe1_high", last1_b, 32'd3);
        chk("t5_strobe2_high", last2_b, 32'd3);
        chk("t5_strobe3_high", last3_b, 32'd3);
        run_b(1'b0, 11'h155, 32'h0, lat, rd);
        chk("t5_load_latency", lat, 32'd20);
        chk("t5_load_rdata", rd, 32'hA5A5A5A5);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
